cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the single-issue core. Replaces the free-running 2-bit phase counter with a handshaked FSM.
- Requests instructions from instruction memory.
- Stalls on memory and on multi-cycle ALU operations.
- Issues PC-advance, instruction-latch and register write-back enables.
- Supports halt and an instruction-fetch timeout fault.
Sits between instr_mem, pc_cntrl, alu and regbank inside cpu.

Parameters:
IMEM_TIMEOUT, 15, wait cycles with imem_req high and no imem_ack before fault is raised (1..255)
TIMEOUT_W, 8, width of the internal timeout counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  level; high = sequence instructions, low = stop at next FETCH boundary
imem_req  output  1  instruction fetch request (registered)
imem_ack  input  1  instruction memory ready/data-valid, sampled while imem_req=1
opcode  input  5  opcode field of latched instruction (inst[31:27])
alu_busy  input  1  high while a multi-cycle ALU operation is in progress
inst_latch_en  output  1  capture instruction word this cycle
pc_enable  output  1  advance/branch PC this cycle
write_enable  output  1  regbank write this cycle
state  output  2  current phase (`FETCH/`DECODE/`EXECUTE/`WRITE_BACK)
halted  output  1  sticky, HLT executed
fault  output  1  sticky, fetch timeout
retired_count  output  32  instructions retired (optional feature)
stall_count  output  32  stall cycles (optional feature)

Behaviour:
- Reset (reset=0, async), all registers cleared:
  - state=`FETCH`; imem_req=0; halted=0; fault=0; timeout counter=0; perf counters=0.
  - All enables are 0.
- FETCH:
  - If run=1 and halted=0 and fault=0, imem_req is set on the next edge.
  - Once set, imem_req holds until imem_ack=1 is sampled. Requests are never withdrawn, even if run falls.
  - inst_latch_en = imem_req & imem_ack (combinational). On that edge: state->`DECODE`, imem_req->0, timeout counter->0.
  - Each wait cycle (imem_req=1, imem_ack=0) increments the timeout counter.
  - When the counter reaches IMEM_TIMEOUT: fault=1, imem_req=0, state stays `FETCH`.
  - If ack and timeout occur in the same cycle, ack wins and no fault is raised.
- DECODE:
  - Exactly 1 cycle.
  - opcode==`HLT`: halted=1 and state->`FETCH`. No PC advance, no write.
  - Otherwise state->`EXECUTE`.
- EXECUTE:
  - Held while alu_busy=1.
  - When alu_busy=0, state->`WRITE_BACK`. Minimum 1 cycle.
- WRITE_BACK:
  - Exactly 1 cycle; pc_enable=1.
  - write_enable=1 unless opcode==`BR`.
  - state->`FETCH`.
- Output decode: pc_enable and write_enable are Moore decodes of state; both are 0 in every other state.
- Latency: zero-wait instruction = 1 request-setup cycle + 4 phases = 5 cycles between retirements.
- run=0 mid-instruction: the current instruction completes through WRITE_BACK, then the sequencer idles in FETCH with imem_req=0.
- halted and fault clear only on reset. While either is set, the sequencer stays in FETCH and asserts no enables.
- Reset mid-operation aborts immediately. No write_enable or pc_enable may glitch high during or after reset deassertion.

Optional Feature:
SEQ_PERF_COUNTERS_EN
- Defined:
  - retired_count increments on every WRITE_BACK cycle.
  - stall_count increments on each FETCH wait cycle (imem_req=1, imem_ack=0) and each EXECUTE cycle with alu_busy=1.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Shared defines.vh:
  - phase encodings `FETCH=0, `DECODE=1, `EXECUTE=2, `WRITE_BACK=3
  - opcodes `BR, `MOV, `CMP, plus new `HLT=5'h1F
  - `WIDTH
- Sub-module seq_timeout: loadable counter with clear, increment and terminal-count flag, parameterised by TIMEOUT_W and IMEM_TIMEOUT.
- All other logic stays in cpu_sequencer.

Test Plan:
1. Reset low 3 cycles then high, run=1, imem_ack tied 1, opcode=`MOV`:
   - state sequence 0,0,1,2,3,0 repeating; write_enable=1 and pc_enable=1 only in state 3.
   - With perf enabled, retired_count=4 after 20 cycles.
2. opcode=`BR`: pc_enable=1 and write_enable=0 in WRITE_BACK.
3. imem_ack low 5 cycles after request, IMEM_TIMEOUT=15:
   - imem_req holds 6 cycles; inst_latch_en pulses once in the ack cycle; fault stays 0.
   - With perf enabled, stall_count=5.
4. imem_ack never asserted, IMEM_TIMEOUT=15:
   - fault=1 after 15 wait cycles, imem_req=0, sequencer stuck in FETCH until reset.
   - Ack arriving on cycle 15 gives fault=0.
5. alu_busy high 3 cycles in EXECUTE: EXECUTE lasts 4 cycles; opcode=`HLT` at DECODE gives halted=1 and no further imem_req.
6. run dropped during EXECUTE, or reset asserted during WRITE_BACK:
   - run drop: instruction retires, then imem_req stays 0.
   - reset: all outputs 0 asynchronously, state=0.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// Shared phase encodings, opcodes and datapath width for the cpu_sequencer slice.
package cpu_sequencer_pkg;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    DECODE     = 2'd1,
    EXECUTE    = 2'd2,
    WRITE_BACK = 2'd3
  } phase_e;

  localparam logic [4:0] OP_MOV = 5'h01;
  localparam logic [4:0] OP_CMP = 5'h02;
  localparam logic [4:0] OP_BR  = 5'h10;
  localparam logic [4:0] OP_HLT = 5'h1F;

  // Branches update the PC only; every other retiring opcode writes the regbank.
  function automatic logic writes_back(input logic [4:0] op);
    return op != OP_BR;
  endfunction

endpackage

// File: rtl/cpu_sequencer_seq_timeout.sv
// Instruction-fetch timeout counter: loadable, clearable, incrementing, with a terminal-count flag.
module seq_timeout #(
  parameter int unsigned TIMEOUT_W    = 8,
  parameter int unsigned IMEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 inc,
  input  logic                 load,
  input  logic [TIMEOUT_W-1:0] load_val,
  output logic                 tc
);

  logic [TIMEOUT_W-1:0] count;

  // tc flags the increment that would make the count reach IMEM_TIMEOUT.
  assign tc = inc && (count == TIMEOUT_W'(IMEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    count <= '0;
    else if (clr)  count <= '0;
    else if (load) count <= load_val;
    else if (inc)  count <= count + 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Handshaked multi-cycle control sequencer (FETCH/DECODE/EXECUTE/WRITE_BACK).
// Optional performance counters enabled by defining SEQ_PERF_COUNTERS_EN.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned IMEM_TIMEOUT = 15,
  parameter int unsigned TIMEOUT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [4:0]  opcode,
  input  logic        alu_busy,
  output logic        inst_latch_en,
  output logic        pc_enable,
  output logic        write_enable,
  output logic [1:0]  state,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired_count,
  output logic [31:0] stall_count
);

  phase_e state_q, state_d;
  logic   req_d, halted_d, fault_d;
  logic   tmo_clr, tmo_tc, fetch_wait;

  assign state         = state_q;
  assign fetch_wait    = (state_q == FETCH) && imem_req && !imem_ack;
  assign inst_latch_en = imem_req && imem_ack;
  assign pc_enable     = (state_q == WRITE_BACK);
  assign write_enable  = (state_q == WRITE_BACK) && writes_back(opcode);

  seq_timeout #(
    .TIMEOUT_W    (TIMEOUT_W),
    .IMEM_TIMEOUT (IMEM_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clr      (tmo_clr),
    .inc      (fetch_wait),
    .load     (1'b0),
    .load_val ('0),
    .tc       (tmo_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      imem_req <= 1'b0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q  <= state_d;
      imem_req <= req_d;
      halted   <= halted_d;
      fault    <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = imem_req;
    halted_d = halted;
    fault_d  = fault;
    tmo_clr  = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_req) begin
          // Ack is checked first so a same-cycle ack beats the timeout.
          if (imem_ack) begin
            state_d = DECODE;
            req_d   = 1'b0;
            tmo_clr = 1'b1;
          end else if (tmo_tc) begin
            fault_d = 1'b1;
            req_d   = 1'b0;
          end
        end else if (run && !halted && !fault) begin
          req_d   = 1'b1;
          tmo_clr = 1'b1;
        end
      end
      DECODE: begin
        if (opcode == OP_HLT) begin
          halted_d = 1'b1;
          state_d  = FETCH;
        end else begin
          state_d  = EXECUTE;
        end
      end
      EXECUTE:    if (!alu_busy) state_d = WRITE_BACK;
      WRITE_BACK: state_d = FETCH;
      default:    state_d = FETCH;
    endcase
  end

`ifdef SEQ_PERF_COUNTERS_EN
  logic exec_stall;
  assign exec_stall = (state_q == EXECUTE) && alu_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_count <= '0;
      stall_count   <= '0;
    end else begin
      if (state_q == WRITE_BACK)     retired_count <= retired_count + 32'd1;
      if (fetch_wait || exec_stall)  stall_count   <= stall_count + 32'd1;
    end
  end
`else
  assign retired_count = '0;
  assign stall_count   = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer with IMEM_TIMEOUT=15.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, run, imem_req, imem_ack, alu_busy;
  logic [4:0]  opcode;
  logic        inst_latch_en, pc_enable, write_enable, halted, fault;
  logic [1:0]  state;
  logic [31:0] retired_count, stall_count;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .IMEM_TIMEOUT (15),
    .TIMEOUT_W    (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .opcode        (opcode),
    .alu_busy      (alu_busy),
    .inst_latch_en (inst_latch_en),
    .pc_enable     (pc_enable),
    .write_enable  (write_enable),
    .state         (state),
    .halted        (halted),
    .fault         (fault),
    .retired_count (retired_count),
    .stall_count   (stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks every output while reset is held; leaves inputs idle and releases reset 1ns after an edge.
  task automatic do_reset(input string tag);
    reset    = 1'b0;
    run      = 1'b0;
    imem_ack = 1'b0;
    alu_busy = 1'b0;
    opcode   = OP_MOV;
    #1;
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_req"},   32'(imem_req), 32'd0);
    chk({tag, "_en"},    32'({inst_latch_en, pc_enable, write_enable}), 32'd0);
    chk({tag, "_stky"},  32'({halted, fault}), 32'd0);
    chk({tag, "_ret"},   retired_count, 32'd0);
    chk({tag, "_stl"},   stall_count, 32'd0);
    step();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_st;

    // Test 1: zero-wait MOV stream
    reset = 1'b0; run = 1'b0; imem_ack = 1'b0; alu_busy = 1'b0; opcode = OP_MOV;
    repeat (2) step();
    do_reset("rst0");
    run = 1'b1; imem_ack = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      case (k % 5)
        1: exp_st = 2'd0;
        2: exp_st = 2'd1;
        3: exp_st = 2'd2;
        4: exp_st = 2'd3;
        default: exp_st = 2'd0;
      endcase
      chk("t1_state", 32'(state), 32'(exp_st));
      chk("t1_we", 32'(write_enable), 32'(exp_st == 2'd3));
      chk("t1_pe", 32'(pc_enable), 32'(exp_st == 2'd3));
    end
`ifdef SEQ_PERF_COUNTERS_EN
    chk("t1_retired", retired_count, 32'd4);
`endif

    // Test 2: BR retires without a regbank write
    do_reset("rst2");
    run = 1'b1; imem_ack = 1'b1; opcode = OP_BR;
    repeat (4) step();
    chk("t2_state", 32'(state), 32'd3);
    chk("t2_pe", 32'(pc_enable), 32'd1);
    chk("t2_we", 32'(write_enable), 32'd0);

    // Test 3: ack arrives after 5 wait cycles
    do_reset("rst3");
    opcode = OP_MOV; run = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t3_req_wait", 32'(imem_req), 32'd1);
      chk("t3_ile_wait", 32'(inst_latch_en), 32'd0);
    end
    step();
    chk("t3_req_6", 32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    #1;
    chk("t3_ile_ack", 32'(inst_latch_en), 32'd1);
    step();
    imem_ack = 1'b0;
    #1;
    chk("t3_state", 32'(state), 32'd1);
    chk("t3_req_off", 32'(imem_req), 32'd0);
    chk("t3_ile_off", 32'(inst_latch_en), 32'd0);
    chk("t3_fault", 32'(fault), 32'd0);
`ifdef SEQ_PERF_COUNTERS_EN
    chk("t3_stall", stall_count, 32'd5);
`endif

    // Test 4a: ack never arrives -> fault after 15 wait cycles
    do_reset("rst4");
    run = 1'b1;
    repeat (15) step();
    chk("t4_req_15", 32'(imem_req), 32'd1);
    chk("t4_fault_15", 32'(fault), 32'd0);
    step();
    chk("t4_fault", 32'(fault), 32'd1);
    chk("t4_req_drop", 32'(imem_req), 32'd0);
    imem_ack = 1'b1;
    repeat (4) step();
    chk("t4_stuck_state", 32'(state), 32'd0);
    chk("t4_stuck_req", 32'(imem_req), 32'd0);
    chk("t4_stuck_en", 32'({inst_latch_en, pc_enable, write_enable}), 32'd0);

    // Test 4b: ack on the 15th wait-cycle slot wins over the timeout
    do_reset("rst4b");
    run = 1'b1;
    repeat (15) step();
    imem_ack = 1'b1;
    #1;
    chk("t4b_ile", 32'(inst_latch_en), 32'd1);
    step();
    chk("t4b_state", 32'(state), 32'd1);
    chk("t4b_fault", 32'(fault), 32'd0);

    // Test 5: 3 busy cycles stretch EXECUTE to 4, then HLT
    do_reset("rst5");
    run = 1'b1; imem_ack = 1'b1;
    repeat (2) step();
    chk("t5_decode", 32'(state), 32'd1);
    alu_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_exec_busy", 32'(state), 32'd2);
    end
    step();
    chk("t5_exec_last", 32'(state), 32'd2);
    alu_busy = 1'b0;
    step();
    chk("t5_wb", 32'(state), 32'd3);
`ifdef SEQ_PERF_COUNTERS_EN
    chk("t5_stall", stall_count, 32'd3);
`endif
    step();
    opcode = OP_HLT;
    repeat (2) step();
    chk("t5_hlt_decode", 32'(state), 32'd1);
    step();
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_hlt_state", 32'(state), 32'd0);
    chk("t5_hlt_en", 32'({pc_enable, write_enable}), 32'd0);
    repeat (5) step();
    chk("t5_no_req", 32'(imem_req), 32'd0);
    chk("t5_still_halt", 32'(halted), 32'd1);

    // Test 6a: run drops during EXECUTE
    do_reset("rst6");
    run = 1'b1; imem_ack = 1'b1;
    repeat (3) step();
    chk("t6_exec", 32'(state), 32'd2);
    run = 1'b0;
    step();
    chk("t6_wb_we", 32'(write_enable), 32'd1);
    repeat (5) step();
    chk("t6_idle_state", 32'(state), 32'd0);
    chk("t6_idle_req", 32'(imem_req), 32'd0);

    // Test 6b: reset asserted in WRITE_BACK clears outputs without a clock edge
    do_reset("rst6b");
    run = 1'b1; imem_ack = 1'b1;
    repeat (4) step();
    chk("t6b_wb", 32'(state), 32'd3);
    reset = 1'b0;
    #1;
    chk("t6b_async_state", 32'(state), 32'd0);
    chk("t6b_async_en", 32'({imem_req, pc_enable, write_enable}), 32'd0);
    step();
    reset = 1'b1;
    #1;
    chk("t6b_release_en", 32'({pc_enable, write_enable}), 32'd0);
    step();
    chk("t6b_restart_req", 32'(imem_req), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
